// File: rtl/msrv32_store_queue_unit.sv
// msrv32_store_queue_unit: aligns execute-stage stores, buffers them in a
// DEPTH-entry FIFO and drains them over a two-phase AHB-style bus.
module msrv32_store_queue_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic              mem_wr_req_in,
  input  logic [1:0]        funct3_in,
  input  logic [AW-1:0]     iadder_in,
  input  logic [XLEN-1:0]   rs2_in,
  input  logic              ahb_ready_in,
  output logic              sq_ready_out,
  output logic              misaligned_store_out,
  output logic [AW-1:0]     ms_riscv32_mp_dmaddr_out,
  output logic [XLEN-1:0]   ms_riscv32_mp_dmdata_out,
  output logic [XLEN/8-1:0] ms_riscv32_mp_dmwr_mask_out,
  output logic              ms_riscv32_mp_req_out,
  output logic [1:0]        ahb_htrans_out,
  output logic              sq_empty_out
);

  localparam int NB = XLEN / 8;
  localparam int LW = $clog2(NB);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  logic clk;
  logic rst;
  assign clk = ms_riscv32_mp_clk_in;
  assign rst = ms_riscv32_mp_rst_in;

  state_t state;
  state_t state_nxt;

  logic [1:0]      size;
  logic [LW-1:0]   lane;
  logic [NB-1:0]   mask_base;
  logic [NB-1:0]   st_mask;
  logic [XLEN-1:0] lane_bits;
  logic [XLEN-1:0] st_data;
  logic [AW-1:0]   st_addr;
  logic            misaligned;
  logic            push;
  logic            pop;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [NB-1:0]   mask_q [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_dec;

  // A doubleword request on a 32-bit datapath degrades to a word.
  always_comb begin
    size = funct3_in;
    if (XLEN == 32 && funct3_in == 2'b11) size = 2'b10;
  end

  always_comb begin
    mask_base = '0;
    unique case (size)
      2'b00:   mask_base = NB'(32'h1);
      2'b01:   mask_base = NB'(32'h3);
      2'b10:   mask_base = NB'(32'hf);
      default: mask_base = '1;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    unique case (size)
      2'b01:   misaligned = iadder_in[0];
      2'b10:   misaligned = |iadder_in[1:0];
      2'b11:   misaligned = |iadder_in[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign lane    = iadder_in[LW-1:0];
  assign st_mask = mask_base << lane;
  assign st_addr = {iadder_in[AW-1:LW], LW'(0)};

  always_comb begin
    lane_bits = '0;
    for (int i = 0; i < NB; i++)
      lane_bits[8*i +: 8] = {8{st_mask[i]}};
  end

  assign st_data = (rs2_in << {lane, 3'b000}) & lane_bits;

  // Space is judged on the registered count only; a same-cycle pop
  // never makes room for a push.
  assign sq_ready_out = (count != CW'(DEPTH));
  assign push = mem_wr_req_in & sq_ready_out & ~misaligned;
  assign pop  = (state == DATA) & ahb_ready_in;
  assign count_dec = count - CW'(1) + CW'(push);
  assign sq_empty_out = (count == '0) & (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      misaligned_store_out <= 1'b0;
    end else begin
      misaligned_store_out <= mem_wr_req_in & misaligned;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= st_addr;
      data_q[wr_ptr] <= st_data;
      mask_q[wr_ptr] <= st_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (count != '0) state_nxt = ADDR;
      ADDR: if (ahb_ready_in) state_nxt = DATA;
      DATA: if (ahb_ready_in)
              state_nxt = (count_dec != '0) ? ADDR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and mask stay on the bus through the data phase.
  always_comb begin
    ms_riscv32_mp_dmaddr_out    = '0;
    ms_riscv32_mp_dmdata_out    = '0;
    ms_riscv32_mp_dmwr_mask_out = '0;
    ms_riscv32_mp_req_out       = 1'b0;
    ahb_htrans_out              = 2'b00;
    unique case (state)
      ADDR: begin
        ms_riscv32_mp_dmaddr_out    = addr_q[rd_ptr];
        ms_riscv32_mp_dmwr_mask_out = mask_q[rd_ptr];
        ms_riscv32_mp_req_out       = 1'b1;
        ahb_htrans_out              = 2'b10;
      end
      DATA: begin
        ms_riscv32_mp_dmaddr_out    = addr_q[rd_ptr];
        ms_riscv32_mp_dmwr_mask_out = mask_q[rd_ptr];
        ms_riscv32_mp_dmdata_out    = data_q[rd_ptr];
        ms_riscv32_mp_req_out       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_msrv32_store_queue_unit.sv
// tb_msrv32_store_queue_unit: 32- and 64-bit store queues driven in
// lockstep, each checked against a transaction-level queue model.
module tb_msrv32_store_queue_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [1:0]  f3;
  logic [31:0] addr;
  logic [63:0] rs2;
  logic        rdy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int phase_of(input logic req, input logic [1:0] ht);
    if (!req) return 0;
    if (ht == 2'b10) return 1;
    if (ht == 2'b00) return 2;
    return 3;
  endfunction

  // Store semantics from first principles: size in bytes, lane, alignment.
  function automatic void model_store(input int xl, input logic [1:0] f,
                                      input logic [31:0] a,
                                      input logic [63:0] d,
                                      output logic mis, output ent_t e);
    int nb;
    int lane;
    nb = (f == 2'b00) ? 1 : (f == 2'b01) ? 2 :
         (f == 2'b11 && xl == 64) ? 8 : 4;
    lane = int'(a % (xl / 8));
    mis = (a % nb) != 0;
    e.addr = a - lane;
    e.mask = 8'(((1 << nb) - 1) << lane);
    e.data = '0;
    for (int i = 0; i < nb; i++)
      if (lane + i < 8) e.data[8*(lane+i) +: 8] = d[8*i +: 8];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int XL = (g == 0) ? 32 : 64;
    logic            sq_ready;
    logic            mis;
    logic            req;
    logic            empty;
    logic [1:0]      htrans;
    logic [AW-1:0]   dmaddr;
    logic [XL-1:0]   dmdata;
    logic [XL/8-1:0] mask;

    msrv32_store_queue_unit #(.XLEN(XL), .DEPTH(DEPTH), .AW(AW)) dut (
      .ms_riscv32_mp_clk_in(clk),
      .ms_riscv32_mp_rst_in(rst),
      .mem_wr_req_in(mem_req),
      .funct3_in(f3),
      .iadder_in(addr),
      .rs2_in(rs2[XL-1:0]),
      .ahb_ready_in(rdy),
      .sq_ready_out(sq_ready),
      .misaligned_store_out(mis),
      .ms_riscv32_mp_dmaddr_out(dmaddr),
      .ms_riscv32_mp_dmdata_out(dmdata),
      .ms_riscv32_mp_dmwr_mask_out(mask),
      .ms_riscv32_mp_req_out(req),
      .ahb_htrans_out(htrans),
      .sq_empty_out(empty)
    );

    initial begin : mon
      ent_t  q[$];
      ent_t  e;
      logic  m;
      logic  exp_mis;
      logic  armed;
      logic  push;
      logic  pop;
      int    ph;
      int    exp_ph;
      int    sz;
      string p;
      armed = 1'b0;
      exp_mis = 1'b0;
      exp_ph = 0;
      p = (g == 0) ? "x32" : "x64";
      forever begin
        @(negedge clk);
        ph = phase_of(req, htrans);
        sz = q.size();
        if (armed) begin
          check({p, "_phase"}, 64'(ph), 64'(exp_ph));
          check({p, "_mis"}, 64'(mis), 64'(exp_mis));
          check({p, "_ready"}, 64'(sq_ready), 64'(sz != DEPTH));
          check({p, "_empty"}, 64'(empty), 64'(sz == 0 && ph == 0));
          if (ph == 0) begin
            check({p, "_idle_ht"}, 64'(htrans), 64'd0);
            check({p, "_idle_addr"}, 64'(dmaddr), 64'd0);
            check({p, "_idle_data"}, 64'(dmdata), 64'd0);
            check({p, "_idle_mask"}, 64'(mask), 64'd0);
          end else if (sz == 0) begin
            check({p, "_bus_no_entry"}, 64'(ph), 64'd0);
          end else begin
            check({p, "_addr"}, 64'(dmaddr), 64'(q[0].addr));
            check({p, "_mask"}, 64'(mask), 64'(q[0].mask));
            if (ph == 2) check({p, "_data"}, 64'(dmdata), q[0].data);
          end
        end
        model_store(XL, f3, addr, rs2, m, e);
        push = mem_req && !rst && sz != DEPTH && !m;
        pop  = ph == 2 && rdy && !rst && sz != 0;
        if (rst) exp_ph = 0;
        else if (ph == 0) exp_ph = (sz != 0) ? 1 : 0;
        else if (ph == 1) exp_ph = rdy ? 2 : 1;
        else if (ph == 2)
          exp_ph = !rdy ? 2 : ((sz - 1 + int'(push)) != 0 ? 1 : 0);
        else exp_ph = 0;
        if (rst) begin
          q.delete();
          exp_mis = 1'b0;
          armed = 1'b1;
        end else begin
          exp_mis = mem_req && m;
          if (pop) void'(q.pop_front());
          if (push) q.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] f, input logic [31:0] a,
                     input logic [63:0] d);
    mem_req = 1'b1;
    f3 = f;
    addr = a;
    rs2 = d;
    step();
    mem_req = 1'b0;
  endtask

  function automatic int ph0();
    return phase_of(g_dut[0].req, g_dut[0].htrans);
  endfunction

  task automatic wait_ph(input int ph, input int budget);
    int n = 0;
    while (ph0() != ph && n < budget) begin
      step();
      n++;
    end
    check($sformatf("wait_ph%0d", ph), 64'(ph0()), 64'(ph));
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (!(g_dut[0].empty && g_dut[1].empty) && n < budget) begin
      step();
      n++;
    end
    check("wait_empty", {g_dut[1].empty, g_dut[0].empty}, 64'd3);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    mem_req = 1'b0;
    f3 = '0;
    addr = '0;
    rs2 = '0;
    rdy = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check("rst_ready", 64'(g_dut[0].sq_ready), 64'd1);
    check("rst_empty", 64'(g_dut[0].empty), 64'd1);
    check("rst_req", 64'(g_dut[0].req), 64'd0);

    put(2'b00, 32'h103, 64'hAABBCCDD);
    wait_ph(1, 8);
    check("sb_addr", 64'(g_dut[0].dmaddr), 64'h100);
    check("sb_mask", 64'(g_dut[0].mask), 64'h8);
    step();
    check("sb_ph_data", 64'(ph0()), 64'd2);
    check("sb_data", 64'(g_dut[0].dmdata), 64'hDD000000);
    step();
    check("sb_idle", 64'(g_dut[0].empty), 64'd1);

    put(2'b01, 32'h206, 64'h1234);
    wait_ph(1, 8);
    check("sh64_addr", 64'(g_dut[1].dmaddr), 64'h200);
    check("sh64_mask", 64'(g_dut[1].mask), 64'hC0);
    step();
    check("sh64_data", 64'(g_dut[1].dmdata), 64'h1234_0000_0000_0000);
    wait_empty(8);

    put(2'b10, 32'h201, 64'h55);
    check("mis_pulse32", 64'(g_dut[0].mis), 64'd1);
    check("mis_pulse64", 64'(g_dut[1].mis), 64'd1);
    step();
    check("mis_clear", 64'(g_dut[0].mis), 64'd0);
    check("mis_empty", 64'(g_dut[1].empty), 64'd1);

    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_req = 1'b1;
      f3 = 2'b10;
      addr = 32'h300 + 32'(4 * i);
      rs2 = 64'h11110000 + 64'(i);
      step();
      if (i == 2) check("room_after3", 64'(g_dut[0].sq_ready), 64'd1);
      if (i == 3) check("full_after4", 64'(g_dut[0].sq_ready), 64'd0);
    end
    mem_req = 1'b0;
    check("full_head", 64'(g_dut[0].dmaddr), 64'h300);
    rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("drain_ht", 64'(g_dut[0].htrans), (k % 2 == 0) ? 64'd2 : 64'd0);
      if (k % 2 == 1)
        check("drain_data", 64'(g_dut[0].dmdata), 64'h11110000 + 64'(k / 2));
      step();
    end
    check("drain_empty", 64'(g_dut[0].empty), 64'd1);

    rdy = 1'b0;
    put(2'b10, 32'h400, 64'hCAFEF00D);
    wait_ph(1, 8);
    for (int k = 0; k < 3; k++) begin
      check("ws_addr_ph", 64'(ph0()), 64'd1);
      check("ws_addr", 64'(g_dut[0].dmaddr), 64'h400);
      check("ws_mask", 64'(g_dut[0].mask), 64'hF);
      step();
    end
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      check("ws_data_ph", 64'(ph0()), 64'd2);
      check("ws_data", 64'(g_dut[0].dmdata), 64'hCAFEF00D);
      step();
    end
    check("ws_no_pop", 64'(ph0()), 64'd2);
    rdy = 1'b1;
    step();
    check("ws_one_pop", 64'(g_dut[0].empty), 64'd1);

    rdy = 1'b0;
    for (int i = 0; i < 3; i++) put(2'b10, 32'h500 + 32'(4 * i), 64'(i));
    wait_ph(1, 8);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    check("rst_in_data", 64'(ph0()), 64'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_ht", 64'(g_dut[0].htrans), 64'd0);
    check("rst_req0", 64'(g_dut[0].req), 64'd0);
    check("rst_empty1", 64'(g_dut[0].empty), 64'd1);
    check("rst_ready1", 64'(g_dut[0].sq_ready), 64'd1);
    rdy = 1'b1;
    n = 0;
    repeat (10) begin
      if (g_dut[0].req || g_dut[1].req) n++;
      step();
    end
    check("rst_quiet", 64'(n), 64'd0);

    put(2'b10, 32'h600, 64'h1);
    wait_ph(1, 8);
    step();
    check("pp_data", 64'(ph0()), 64'd2);
    put(2'b10, 32'h604, 64'h2);
    check("pp_addr_ph", 64'(ph0()), 64'd1);
    check("pp_addr", 64'(g_dut[0].dmaddr), 64'h604);
    check("pp_not_empty", 64'(g_dut[0].empty), 64'd0);
    wait_empty(8);

    repeat (1500) begin
      mem_req = 1'($urandom_range(0, 1));
      f3 = 2'($urandom);
      addr = 32'h1000 + 32'($urandom_range(0, 255));
      rs2 = {$urandom, $urandom};
      rdy = $urandom_range(0, 9) < 7;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    mem_req = 1'b0;
    rst = 1'b0;
    rdy = 1'b1;
    wait_empty(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/msrv32_store_queue_unit.md
Name: msrv32_store_queue_unit

Overview:
Parametrised successor to the combinational store path. It accepts store requests from the execute stage and aligns data and byte-enables for byte, halfword, word and (XLEN=64) doubleword stores. Requests are buffered in a DEPTH-entry FIFO and drained to the data-memory bus through a two-phase AHB-style address/data handshake. The pipeline therefore only stalls when the queue is full, and misaligned stores are flagged instead of issued.

Parameters:
XLEN, 32, data path width in bits; 32 or 64 only.
DEPTH, 4, store-queue entries; power of two, minimum 2.
AW, 32, address width.

Ports:
ms_riscv32_mp_clk_in  input  1  single clock; all state updates on its rising edge.
ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset.
mem_wr_req_in  input  1  store request valid from execute stage.
funct3_in  input  2  size code: 00 byte, 01 half, 10 word, 11 double (treated as word when XLEN=32).
iadder_in  input  AW  byte address of the store.
rs2_in  input  XLEN  store data, LSB-justified.
ahb_ready_in  input  1  bus HREADY.
sq_ready_out  output  1  high when the queue can accept (not full).
misaligned_store_out  output  1  one-cycle registered pulse on a rejected misaligned store.
ms_riscv32_mp_dmaddr_out  output  AW  head-entry address, aligned to XLEN/8 bytes.
ms_riscv32_mp_dmdata_out  output  XLEN  head-entry aligned data.
ms_riscv32_mp_dmwr_mask_out  output  XLEN/8  byte write enables.
ms_riscv32_mp_req_out  output  1  bus request, high in ADDR and DATA states.
ahb_htrans_out  output  2  10 (NONSEQ) in ADDR state, otherwise 00 (IDLE).
sq_empty_out  output  1  queue empty and FSM in IDLE.

Behaviour:
- Lane select: lane = iadder_in[log2(XLEN/8)-1:0]. Data is rs2_in LSBs shifted left by 8*lane. Non-enabled lanes are zero.
- Masks: byte gives 1 bit at lane; half gives 2 bits; word gives 4 bits; double gives all 8 bits.
- Misaligned conditions:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - double with addr[2:0]!=0 (XLEN=64);
  - XLEN=32 with funct3=11 is checked as word.
- A misaligned store is never enqueued. misaligned_store_out pulses high the cycle after the request, whether or not the queue is full.
- Enqueue condition: mem_wr_req_in & sq_ready_out & aligned. The entry holds aligned address, data and mask. sq_ready_out = (count != DEPTH), decoded from registered count only.
  - A pop in the same cycle does not free space for a push when full.
  - Push on empty and pop on the last entry may coincide; count stays consistent.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Drain FSM (registered state: IDLE, ADDR, DATA):
  - IDLE: if count!=0, go to ADDR next cycle.
  - ADDR: drive address and mask from the head entry, htrans=10, req=1. If ahb_ready_in, go to DATA; else hold ADDR with address and mask stable.
  - DATA: drive head data, htrans=00, req=1. If ahb_ready_in, pop the head; go to ADDR if (count-1+push)!=0, else IDLE. If not ready, hold with data stable.
- Latency: a store accepted at edge N appears in ADDR in cycle N+2 when the queue was empty. Minimum bus occupancy is 2 cycles per store. Back-to-back stores issue every 2 cycles with ahb_ready_in held high.
- Outputs in IDLE: address, data and mask are 0, req=0, htrans=00.
- Reset (at any time, including mid-transfer):
  - State goes to IDLE; pointers and count go to 0; pending entries are discarded.
  - misaligned_store_out=0, sq_ready_out=1, sq_empty_out=1, htrans=00, req=0.
  - All bus outputs read 0 in the cycle after reset is sampled.
- An entry is never popped without a DATA-phase ahb_ready_in. Outputs never change while ahb_ready_in is low in ADDR or DATA.

Test Plan:
- XLEN=32 sb, addr 0x103, rs2 0xAABBCCDD: ADDR cycle shows dmaddr 0x100, mask 1000. DATA cycle shows data 0xDD000000. Pop occurs; FSM returns to IDLE.
- XLEN=64 sh, addr 0x206, rs2 0x1234: dmaddr 0x200, mask 11000000, data 0x1234_0000_0000_0000. sw to 0x201: no enqueue, misaligned_store_out pulses 1 cycle, queue stays empty.
- DEPTH=4, five sw requests on consecutive cycles with ahb_ready_in=0: sq_ready_out drops after the 4th request and the 5th is refused. Releasing ahb_ready_in drains 4 stores in FIFO order, one every 2 cycles, with htrans sequence 10,00 repeating.
- Wait states: ahb_ready_in low for 3 cycles in ADDR, then 2 cycles in DATA. Address, mask and data hold stable; exactly one pop occurs.
- Reset asserted in DATA with 3 entries queued: next cycle htrans=00, req=0, sq_empty_out=1, sq_ready_out=1. No further bus activity occurs.
- Simultaneous push and pop with count=1: count stays 1 and FSM goes DATA to ADDR with the new entry's address.
